// File: rtl/serial_deserializer.sv
// Serial frame receiver: start bit (0), WIDTH data bits LSB first, one parity bit.
// D is sampled only on edges where the qualifier E is high. Every output is registered.
module serial_deserializer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ODD_PAR = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             D,
    input  logic             E,
    output logic [WIDTH-1:0] DATA,
    output logic             VALID,
    output logic             PERR,
    output logic             BUSY
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    // Odd parity flags an error on an even count of ones; even parity on an odd count.
    localparam logic PAR_SENSE = (ODD_PAR != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA_S,
        PAR_S
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               busy_q, busy_d;

    // State and datapath registers. Reset clears everything without waiting for a clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic. Any edge with E low leaves every register except VALID untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;

        case (state_q)
            IDLE: begin
                if (E && !D) begin
                    state_d = DATA_S;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            DATA_S: begin
                if (E) begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            shift_d[i] = D;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = PAR_S;
                    end
                end
            end
            PAR_S: begin
                if (E) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = (^{shift_q, D}) ^ PAR_SENSE;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // BUSY is registered, so it follows the state being entered on this edge.
        busy_d = (state_d != IDLE);
    end

    assign DATA  = data_q;
    assign VALID = valid_q;
    assign PERR  = perr_q;
    assign BUSY  = busy_q;

endmodule
